// File: rtl/pic_pkg.sv
// Shared definitions for the PIC priority resolver: index-width helper,
// default vector base and EOI mode encodings.
package pic_pkg;

  localparam logic [7:0] VECTOR_BASE_DEF = 8'h20;

  typedef enum logic {
    EOI_NONSPEC = 1'b0,
    EOI_SPEC    = 1'b1
  } eoi_mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pic_prio_pick.sv
// Rotating priority picker: hi_ptr is the highest-priority position, then
// descending mod N. Returns the winning channel index.
module pic_prio_pick
  import pic_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] hi_ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  req_rot;
  logic [IW-1:0] pos;
  logic [IW:0]   sum;

  // req_rot[N-1] holds the channel at hi_ptr, lower bits follow in descending priority
  assign req_rot = N'({req, req} >> ({1'b0, hi_ptr} + (IW+1)'(1)));

  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      if (req_rot[k]) begin
        found = 1'b1;
        pos   = IW'(k);
      end
    end
    sum = {1'b0, pos} + {1'b0, hi_ptr} + (IW+1)'(1);
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/pic_priority_resolver.sv
// N-channel interrupt priority resolver: IRR/IMR/ISR registers, fully nested
// fixed or rotating priority, INTA vector delivery and EOI handling.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter int         N           = 8,
  parameter int         IDX_W       = 3,
  parameter bit         EDGE_MODE   = 1'b1,
  parameter logic [7:0] VECTOR_BASE = VECTOR_BASE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     irq,
  input  logic             imr_we,
  input  logic [N-1:0]     imr_wdata,
  input  logic             rotate_en,
  input  logic             inta,
  input  logic             eoi,
  input  logic             eoi_spec,
  input  logic [IDX_W-1:0] eoi_idx,
  output logic             int_o,
  output logic             vec_valid,
  output logic             spurious,
  output logic [7:0]       vec,
  output logic [N-1:0]     isr_o,
  output logic [N-1:0]     irr_o
);

  logic [N-1:0]     sync1_q, sync2_q, sync3_q;
  logic [N-1:0]     irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [IDX_W-1:0] hi_ptr_q, hi_ptr_d;
  logic             int_q, int_d, vec_valid_q, vec_valid_d, spurious_q, spurious_d;
  logic [7:0]       vec_q, vec_d;

  logic [N-1:0]     irr, edge_set, clr_mask, set_mask;
  logic             req_found, isr_found, accept, eoi_hit;
  logic [IDX_W-1:0] req_idx, isr_idx, eoi_tgt;

  function automatic logic [IDX_W-1:0] rank_of(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] hp);
    logic [IDX_W+1:0] t;
    t = {2'b00, idx} + (IDX_W+2)'(N) - {2'b00, hp} - (IDX_W+2)'(1);
    if (t >= (IDX_W+2)'(N)) t = t - (IDX_W+2)'(N);
    return t[IDX_W-1:0];
  endfunction

  assign irr = EDGE_MODE ? irr_q : sync2_q;

  pic_prio_pick #(.N(N)) u_req_pick (
    .req    (irr & ~imr_q),
    .hi_ptr (hi_ptr_q),
    .found  (req_found),
    .idx    (req_idx)
  );

  pic_prio_pick #(.N(N)) u_isr_pick (
    .req    (isr_q),
    .hi_ptr (hi_ptr_q),
    .found  (isr_found),
    .idx    (isr_idx)
  );

  always_comb begin
    accept  = inta && !vec_valid_q;
    eoi_hit = 1'b0;
    eoi_tgt = '0;
    if (eoi) begin
      if (eoi_mode_e'(eoi_spec) == EOI_SPEC) begin
        if (({1'b0, eoi_idx} < (IDX_W+1)'(N)) && isr_q[eoi_idx]) begin
          eoi_hit = 1'b1;
          eoi_tgt = eoi_idx;
        end
      end else if (isr_found) begin
        eoi_hit = 1'b1;
        eoi_tgt = isr_idx;
      end
    end
    clr_mask = eoi_hit ? (N'(1) << eoi_tgt) : '0;
    set_mask = (accept && req_found) ? (N'(1) << req_idx) : '0;

    // EOI clear applies first so an acknowledge of the same channel keeps it in service
    isr_d    = (isr_q & ~clr_mask) | set_mask;
    edge_set = sync2_q & ~sync3_q;
    irr_d    = EDGE_MODE ? ((irr_q & ~set_mask) | edge_set) : '0;
    imr_d    = imr_we ? imr_wdata : imr_q;

    hi_ptr_d = hi_ptr_q;
    if (eoi_hit && rotate_en) begin
      hi_ptr_d = (eoi_tgt == '0) ? IDX_W'(N-1) : eoi_tgt - IDX_W'(1);
    end

    int_d = req_found &&
            (!isr_found || (rank_of(req_idx, hi_ptr_q) > rank_of(isr_idx, hi_ptr_q)));

    vec_valid_d = accept;
    spurious_d  = accept && !req_found;
    vec_d       = vec_q;
    if (accept) begin
      vec_d = req_found ? (VECTOR_BASE + 8'(req_idx)) : (VECTOR_BASE + 8'(N-1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '1;
      hi_ptr_q    <= IDX_W'(N-1);
      int_q       <= 1'b0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
      vec_q       <= 8'h00;
    end else begin
      sync1_q     <= irq;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      hi_ptr_q    <= hi_ptr_d;
      int_q       <= int_d;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
      vec_q       <= vec_d;
    end
  end

  assign int_o     = int_q;
  assign vec_valid = vec_valid_q;
  assign spurious  = spurious_q;
  assign vec       = vec_q;
  assign isr_o     = isr_q;
  assign irr_o     = irr;

endmodule
